// File: rtl/sysarray_pkg.sv
// Shared definitions for the matmul systolic array: FSM state encoding,
// FLUSH length and the accumulator-to-output saturation helper.
package sysarray_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Cycles needed after the last beat for it to reach PE(N-1,N-1).
  function automatic int flush_len(input int n);
    return 2 * n - 2;
  endfunction

  // Clamp a sign-extended accumulator value to the signed out_w range.
  function automatic longint sat_val(input longint v, input int out_w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (out_w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/matmul_engine_pe.sv
// Processing element: registers a/b one cycle on their way across the grid
// and accumulates their signed product every cycle into an ACC_W register.
module pe #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic signed [A_W-1:0]   a_in,
  input  logic signed [B_W-1:0]   b_in,
  output logic signed [A_W-1:0]   a_out,
  output logic signed [B_W-1:0]   b_out,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [A_W+B_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;

  assign prod     = a_in * b_in;
  assign prod_ext = ACC_W'(prod);

  // Pass operands on to the neighbours and accumulate (wrapping at ACC_W).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// N x N output-stationary systolic matrix multiplier C = A * B.
// A rows enter from the left, B columns from the top, both skewed so that
// A[i][k] and B[k][j] meet in PE(i,j). Results are streamed out row by row.
// Optional build macro: SYSARRAY_SAT_EN -- saturate results to OUT_W instead
// of keeping the low OUT_W accumulator bits.
module matmul_engine
  import sysarray_pkg::*;
#(
  parameter int N     = 4,
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int K_MAX = 16,
  parameter int ACC_W = 20,
  parameter int OUT_W = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            start_ready,
  input  logic [$clog2(K_MAX+1)-1:0]      k_len,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N-1:0][A_W-1:0]           in_a,
  input  logic [N-1:0][B_W-1:0]           in_b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N-1:0][OUT_W-1:0]         out_row,
  output logic [$clog2(N)-1:0]            out_ridx,
  output logic                            busy,
  output logic                            done
);

  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = $clog2(N);
  localparam int FL = flush_len(N);
  localparam int FW = $clog2(2 * N);

  state_t          state;
  logic [KW-1:0]   k_reg;
  logic [KW-1:0]   beat_cnt;
  logic [FW-1:0]   flush_cnt;
  logic [RW-1:0]   row_cnt;
  logic            done_reg;
  logic            accept;
  logic            pe_clr;
  logic            last_row;

  // Operand wires between PEs; column N / row N are the unused far edges.
  logic signed [A_W-1:0]   a_h     [N][N+1];
  logic signed [B_W-1:0]   b_v     [N+1][N];
  logic signed [ACC_W-1:0] acc_arr [N][N];

  assign start_ready = (state == IDLE);
  assign in_ready    = (state == FEED);
  assign out_valid   = (state == DRAIN);
  assign busy        = (state != IDLE);
  assign done        = done_reg;
  assign out_ridx    = out_valid ? row_cnt : '0;
  assign accept      = in_valid & in_ready;
  assign pe_clr      = start & start_ready;
  assign last_row    = (row_cnt == RW'(N - 1));

  // Job sequencing: IDLE -> FEED -> FLUSH -> DRAIN -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k_reg     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_cnt   <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_reg    <= k_len;
            beat_cnt <= '0;
            row_cnt  <= '0;
            state    <= (k_len == '0) ? DRAIN : FEED;
          end
        end
        FEED: begin
          if (accept) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (beat_cnt + KW'(1) == k_reg) begin
              flush_cnt <= '0;
              state     <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FW'(FL - 1)) begin
            row_cnt <= '0;
            state   <= DRAIN;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (last_row) begin
              done_reg <= 1'b1;
              state    <= IDLE;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Input skew: lane gi is delayed gi cycles; non-accepted cycles inject zero.
  genvar gi, gj;
  for (gi = 0; gi < N; gi++) begin : g_lane
    logic signed [A_W-1:0] a_beat;
    logic signed [B_W-1:0] b_beat;
    assign a_beat = accept ? $signed(in_a[gi]) : '0;
    assign b_beat = accept ? $signed(in_b[gi]) : '0;
    if (gi == 0) begin : g_direct
      assign a_h[gi][0] = a_beat;
      assign b_v[0][gi] = b_beat;
    end else begin : g_skew
      logic signed [A_W-1:0] a_sr [gi];
      logic signed [B_W-1:0] b_sr [gi];
      // Shift every cycle so bubbles keep the lanes aligned.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < gi; k++) begin
            a_sr[k] <= '0;
            b_sr[k] <= '0;
          end
        end else begin
          a_sr[0] <= a_beat;
          b_sr[0] <= b_beat;
          for (int k = 1; k < gi; k++) begin
            a_sr[k] <= a_sr[k-1];
            b_sr[k] <= b_sr[k-1];
          end
        end
      end
      assign a_h[gi][0] = a_sr[gi-1];
      assign b_v[0][gi] = b_sr[gi-1];
    end
  end

  for (gi = 0; gi < N; gi++) begin : g_row
    for (gj = 0; gj < N; gj++) begin : g_col
      pe #(
        .A_W  (A_W),
        .B_W  (B_W),
        .ACC_W(ACC_W)
      ) u_pe (
        .clk  (clk),
        .rst  (rst),
        .clr  (pe_clr),
        .a_in (a_h[gi][gj]),
        .b_in (b_v[gi][gj]),
        .a_out(a_h[gi][gj+1]),
        .b_out(b_v[gi+1][gj]),
        .acc  (acc_arr[gi][gj])
      );
    end
  end

  // Present the selected result row; zero outside DRAIN.
  always_comb begin
    out_row = '0;
    if (state == DRAIN) begin
      for (int j = 0; j < N; j++) begin
`ifdef SYSARRAY_SAT_EN
        out_row[j] = OUT_W'(sat_val(longint'(acc_arr[row_cnt][j]), OUT_W));
`else
        out_row[j] = acc_arr[row_cnt][j][OUT_W-1:0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_matmul_engine.sv
// Scoreboard bench for matmul_engine: expected rows are computed from the
// operand matrices and queued when a job is set up, then popped as the
// DUT streams result rows.
module tb_matmul_engine;

  localparam int N     = 4;
  localparam int A_W   = 8;
  localparam int B_W   = 8;
  localparam int K_MAX = 16;
  localparam int ACC_W = 20;
  localparam int OUT_W = 16;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int RW    = $clog2(N);

  typedef struct {
    logic [RW-1:0]        ridx;
    logic [N*OUT_W-1:0]   row;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic                     start_ready;
  logic [KW-1:0]            k_len;
  logic                     in_valid;
  logic                     in_ready;
  logic [N-1:0][A_W-1:0]    in_a;
  logic [N-1:0][B_W-1:0]    in_b;
  logic                     out_valid;
  logic                     out_ready;
  logic [N-1:0][OUT_W-1:0]  out_row;
  logic [RW-1:0]            out_ridx;
  logic                     busy;
  logic                     done;

  int   a_m [N][K_MAX];
  int   b_m [K_MAX][N];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_errors = 0;

  matmul_engine #(
    .N(N), .A_W(A_W), .B_W(B_W), .K_MAX(K_MAX), .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
    .k_len(k_len), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_ridx(out_ridx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference for one result element: wrap at ACC_W, then wrap or clamp to OUT_W.
  function automatic logic [OUT_W-1:0] model_out(input longint v);
    logic [ACC_W-1:0] t;
    longint           s;
    longint           hi;
    t  = ACC_W'(v);
    s  = longint'($signed(t));
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
`ifdef SYSARRAY_SAT_EN
    if (s > hi) s = hi;
    if (s < -hi - 1) s = -hi - 1;
`endif
    return OUT_W'(s);
  endfunction

  task automatic push_expected(input int k);
    exp_t   e;
    longint sum;
    for (int i = 0; i < N; i++) begin
      e.ridx = RW'(i);
      e.row  = '0;
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int kk = 0; kk < k; kk++) sum += longint'(a_m[i][kk]) * longint'(b_m[kk][j]);
        e.row[j*OUT_W +: OUT_W] = model_out(sum);
      end
      sb.push_back(e);
    end
  endtask

  task automatic fill_rand(input int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < N; i++) begin
        a_m[i][kk] = int'($urandom_range(255)) - 128;
        b_m[kk][i] = int'($urandom_range(255)) - 128;
      end
    end
  endtask

  task automatic start_job(input int k);
    int c;
    c = 0;
    while (!start_ready && c < 100) begin
      tick;
      c++;
    end
    check("start_ready_wait", start_ready, 1);
    k_len = KW'(k);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    $display("job start k_len=%0d", k);
  endtask

  task automatic feed(input int k, input int bubble_pct);
    int n;
    int c;
    bit v;
    bit acc;
    n = 0;
    c = 0;
    while (n < k && c < 500) begin
      v = ($urandom_range(99) >= bubble_pct);
      in_valid = v;
      for (int i = 0; i < N; i++) begin
        in_a[i] = v ? A_W'(a_m[i][n]) : A_W'($urandom);
        in_b[i] = v ? B_W'(b_m[n][i]) : B_W'($urandom);
      end
      acc = v && in_ready;
      tick;
      if (acc) n++;
      c++;
    end
    in_valid = 1'b0;
    check("feed_beats", n, k);
  endtask

  task automatic collect(input int stall_row, input int stall_cyc, input bit hold_start);
    exp_t e;
    int   c;
    for (int r = 0; r < N; r++) begin
      out_ready = 1'b1;
      c = 0;
      while (!out_valid && c < 100) begin
        tick;
        c++;
      end
      check("out_valid", out_valid, 1);
      check("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) e = sb.pop_front();
      check("ridx", out_ridx, e.ridx);
      check("row", out_row, e.row);
      check("start_ready_drain", start_ready, 0);
      check("in_ready_drain", in_ready, 0);
      $display("row ridx=%0d data=%h", out_ridx, out_row);
      if (r == stall_row) begin
        out_ready = 1'b0;
        repeat (stall_cyc) begin
          tick;
          check("stall_valid", out_valid, 1);
          check("stall_ridx", out_ridx, e.ridx);
          check("stall_row", out_row, e.row);
        end
        out_ready = 1'b1;
      end
      tick;
    end
    out_ready = 1'b0;
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    check("start_ready_at_done", start_ready, 1);
    if (!hold_start) begin
      tick;
      check("done_low", done, 0);
      check("busy_idle", busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    k_len     = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (2) tick;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_ridx", out_ridx, 0);
    rst = 1'b0;
    tick;
    check("post_rst_start_ready", start_ready, 1);

    // Identity A times B[k][j] = 4k + j, no bubbles.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++) begin
        a_m[i][k] = (i == k) ? 1 : 0;
        b_m[k][i] = 4 * k + i;
      end
    push_expected(4);
    start_job(4);
    feed(4, 0);
    collect(-1, 0, 0);

    // Most negative operands with bubbles: each sum is 3 * 16384.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) begin
        a_m[i][k] = -128;
        b_m[k][i] = -128;
      end
    push_expected(3);
    start_job(3);
    feed(3, 40);
    collect(-1, 0, 0);

    // Empty inner dimension: straight to DRAIN with zero rows.
    push_expected(0);
    start_job(0);
    check("k0_in_ready", in_ready, 0);
    collect(-1, 0, 0);

    // Random data, back-pressure on row 1 for 5 cycles.
    fill_rand(5);
    push_expected(5);
    start_job(5);
    feed(5, 25);
    collect(1, 5, 0);

    // Reset in the middle of FEED, then a fresh job.
    fill_rand(4);
    start_job(4);
    in_valid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < N; i++) begin
        in_a[i] = A_W'(a_m[i][b]);
        in_b[i] = B_W'(b_m[b][i]);
      end
      tick;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    tick;
    rst = 1'b0;
    tick;
    fill_rand(2);
    push_expected(2);
    start_job(2);
    feed(2, 30);
    collect(-1, 0, 0);

    // start held during FLUSH/DRAIN is ignored; next job begins from IDLE.
    fill_rand(3);
    push_expected(3);
    start_job(3);
    feed(3, 20);
    fill_rand(1);
    push_expected(1);
    k_len = KW'(1);
    start = 1'b1;
    collect(-1, 0, 1);
    tick;
    start = 1'b0;
    check("second_job_busy", busy, 1);
    check("second_job_done_low", done, 0);
    check("second_job_in_ready", in_ready, 1);
    feed(1, 0);
    collect(-1, 0, 0);

    // Full-depth random job with heavy bubbles.
    fill_rand(K_MAX);
    push_expected(K_MAX);
    start_job(K_MAX);
    feed(K_MAX, 50);
    collect(2, 3, 0);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/matmul_engine.md
MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 SHALL have parameter N, default 4: array dimension (N x N PEs), range 2..16.
REQ-002 SHALL have parameter A_W, default 8: signed A-operand width.
REQ-003 SHALL have parameter B_W, default 8: signed B-operand width.
REQ-004 SHALL have parameter K_MAX, default 16: maximum inner dimension.
REQ-005 SHALL have parameter ACC_W, default 20: PE accumulator width.
REQ-006 SHALL have parameter OUT_W, default 16: result width, OUT_W <= ACC_W.
REQ-007 SHALL have port clk, input, 1: single clock; one clock, all state on its rising edge.
REQ-008 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-009 SHALL have ports start (in, 1) and start_ready (out, 1): job request handshake.
REQ-010 SHALL have port k_len, input, $clog2(K_MAX+1): inner dimension, sampled on start handshake.
REQ-011 SHALL have ports in_valid (in, 1), in_ready (out, 1), in_a (in, N x A_W signed) and in_b (in, N x B_W signed): one operand beat, in_a[i]=A[i][k], in_b[j]=B[k][j].
REQ-012 SHALL have ports out_valid (in/out: out, 1), out_ready (in, 1), out_row (out, N x OUT_W signed) and out_ridx (out, $clog2(N)): result row stream.
REQ-013 SHALL have ports busy (out, 1) and done (out, 1): status; done is a one-cycle pulse.

Function
REQ-014 SHALL compute C = A(N x k_len) * B(k_len x N) with signed arithmetic; each product is sign-extended to ACC_W and accumulated with wrap at ACC_W.
REQ-015 SHALL implement FSM states IDLE, FEED, FLUSH, DRAIN.
REQ-016 IDLE: start_ready=1; on start&start_ready, latch k_len, assert PE clear for exactly that cycle, go to FEED (k_len>=1) or DRAIN (k_len=0, all results zero).
REQ-017 FEED: in_ready=1; beat accepted when in_valid&in_ready; after the k_len-th accepted beat, go to FLUSH next cycle.
REQ-018 Skew: A lane i and B lane j SHALL be delayed i and j cycles respectively by shift registers that shift every cycle and insert zero when no beat is accepted, so bubbles never misalign operands.
REQ-019 FLUSH: SHALL last exactly 2N-2 cycles (counter), in_ready=0, zeros injected; then DRAIN.
REQ-020 DRAIN: out_valid=1, out_row[j]=C[r][j], out_ridx=r, r starting at 0; r advances on out_valid&out_ready; out_row stable while out_ready=0.
REQ-021 On acceptance of row N-1: done=1 for one cycle, go to IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 start while not in IDLE SHALL be ignored (start_ready=0).
REQ-024 PE contract: a/b pass-through registered one cycle; acc += a*b every cycle; synchronous clear.

Reset
REQ-025 rst SHALL asynchronously force IDLE, clear skew registers, counters and all PE accumulators, including mid-FEED/FLUSH/DRAIN.
REQ-026 During and after reset: start_ready=1 (once rst deasserts), in_ready=0, out_valid=0, out_row=0, out_ridx=0, busy=0, done=0.

Configuration
REQ-027 With SYSARRAY_SAT_EN defined, out_row SHALL saturate each ACC_W accumulator to the OUT_W signed range.
REQ-028 Without SYSARRAY_SAT_EN, out_row SHALL be the low OUT_W bits of the accumulator (wrap).

Structure
REQ-029 Package sysarray_pkg SHALL hold the FSM state enum, the FLUSH length function (2N-2) and the saturation function.
REQ-030 The existing pe module SHALL be the only sub-module, instantiated N x N via generate.

Verification
REQ-031 N=4, k_len=4, A=identity, B[k][j]=4k+j, no bubbles -> rows 0..3 equal B rows; done one cycle after row 3 accepted.
REQ-032 k_len=3, all A=-128, all B=-128, random in_valid bubbles -> every C=49152 with ACC_W=20; with SYSARRAY_SAT_EN and OUT_W=16 every out_row = 32767.
REQ-033 k_len=0 -> DRAIN immediately, four rows of zeros, no in_ready assertion.
REQ-034 out_ready held low 5 cycles on row 1 -> out_row/out_ridx=1 stable, no row skipped or duplicated.
REQ-035 rst asserted mid-FEED after 2 beats, then new job k_len=2 -> results reflect only the new job's beats.
REQ-036 start held high during DRAIN -> ignored; second job starts only after return to IDLE.
